inagu_ctrl: RTL and testbench
=============================

// Module: inagu_ctrl
// PURPOSE
//  Job sequencer for the input/weight address generator (inagu) and the downstream
//  shift-accumulator. Accepts one job per start handshake, clears the AGUs, steps them
//  for a programmed number of cycles, then drains the datapath pipeline.
//  Emits pipeline-aligned accumulator controls (load/acc/shift/output) and a done pulse.
// PARAMETERS
//  BCNT     32  width of the job step countdown
//  NJUMPS   5   number of AGU jump levels (matches inagu)
//  LATENCY  3   cycles from agu_en to operands valid at the accumulator, >=1
// PORTS
//  clk           in   1        clock
//  clr           in   1        synchronous active-high reset
//  start         in   1        job request; accepted when start && start_rdy
//  start_rdy     out  1        high only in IDLE
//  cfg_count     in   BCNT     total AGU steps for the job, sampled on accept
//  cfg_out_sel   in   NJUMPS   jump mask marking an accumulator output boundary, sampled on accept
//  agu_clr       out  1        clear to inagu
//  agu_en        out  1        step enable to inagu
//  agu_sh        in   1        inagu sh_out (zig-zag shift), same cycle as agu_en
//  agu_on_j      in   NJUMPS   inagu wagu_on_j, same cycle as agu_en
//  shacc_load    out  1        accumulator loads instead of adding (first term of an output)
//  shacc_acc     out  1        accumulator operand valid
//  shacc_sh      out  1        accumulator shifts before adding
//  out_step      out  1        accumulator result complete this cycle
//  busy          out  1        high in every state except IDLE
//  done          out  1        one-cycle pulse when job fully drained
// BEHAVIOUR
//  - Reset (clr): state IDLE; every output 0 except start_rdy=1; countdown, drain counter,
//    delay pipes and load flag cleared. clr mid-job aborts it: no done pulse.
//  - FSM: IDLE -accept-> CLEAR; CLEAR (1 cyc, agu_clr=1) -> RUN, or -> DRAIN if cfg_count==0;
//    RUN: agu_en=1, countdown-1 per step; last step (countdown==1) -> DRAIN;
//    DRAIN: counts LATENCY cycles -> DONE; DONE (1 cyc, done=1) -> IDLE.
//  - start while busy is ignored (not queued). Accept-to-first-agu_en = 2 cycles.
//  - Raw per-step terms (cycle of agu_en): acc_r=1; sh_r=agu_sh;
//    out_r=|(cfg_out_sel & agu_on_j); load_r=load_flag. load_flag set in CLEAR,
//    set by any step with out_r=1, cleared by any step with out_r=0.
//  - shacc_acc/shacc_sh/shacc_load/out_step = acc_r/sh_r/load_r/out_r delayed exactly
//    LATENCY cycles; all qualified by acc (0 when no step was issued).
//  - Zero-length job: CLEAR, DRAIN, DONE; no agu_en, no shacc_*; done 2+LATENCY cycles after accept.
//  - Last shacc_acc occurs in the final DRAIN cycle; done follows next cycle.
//  - Countdown is BCNT wide, no wrap: cfg_count=2^BCNT-1 runs that many steps.
// CONFIGURATION
//  INAGU_CTRL_STALL_EN defined: extra port stall (in, 1). In RUN, stall=1 forces agu_en=0,
//  freezes countdown and load_flag, injects a bubble (acc_r=0) into the delay pipes;
//  DRAIN/CLEAR/DONE ignore stall. Not defined: no stall port; RUN steps every cycle.
// STRUCTURE
//  Package inagu_ctrl_pkg: state enum (IDLE, CLEAR, RUN, DRAIN, DONE), default widths,
//  struct of delayed terms {load, acc, sh, out}.
//  Sub-module ctrl_delay #(W, DEPTH): clr-reset shift register, used for the 4-bit term pipe.
// TESTING
//  1 Reset: clr 3 cycles -> start_rdy=1, all other outputs 0; no agu_en afterwards.
//  2 cfg_count=4, sel=0b00010, on_j[1] on step 2 -> agu_en 4 cycles, shacc_acc 4 cycles
//    starting LATENCY after first agu_en, shacc_load on steps 1 and 3, out_step on step 2, done once.
//  3 cfg_count=0 -> no agu_en/shacc_acc; done exactly 2+LATENCY cycles after accept.
//  4 start held high across job, second job cfg changed mid-run -> ignored until IDLE,
//    second job uses values sampled at its own accept.
//  5 clr asserted 2 cycles into RUN (count=10) -> next cycle IDLE, outputs 0, no done.
//  6 STALL_EN: count=3, stall on cycle 2 of RUN -> 3 agu_en total over 4 cycles, one
//    shacc_acc bubble, done delayed by 1 cycle versus no stall.

Source files
------------

// File: rtl/inagu_ctrl_pkg.sv
// Shared types and default sizes for the inagu job sequencer.
// Optional feature macro used by this slice: INAGU_CTRL_STALL_EN.
package inagu_ctrl_pkg;

    localparam int DEF_BCNT    = 32;
    localparam int DEF_NJUMPS  = 5;
    localparam int DEF_LATENCY = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One accumulator control term, carried through the latency pipe.
    typedef struct packed {
        logic load;
        logic acc;
        logic sh;
        logic out;
    } term_t;

    localparam int TERM_W = $bits(term_t);

    // Every control is meaningless without a valid operand, so gate all by acc.
    function automatic term_t qualify_term(input term_t t);
        term_t q;
        q.acc  = t.acc;
        q.load = t.load & t.acc;
        q.sh   = t.sh & t.acc;
        q.out  = t.out & t.acc;
        return q;
    endfunction

endpackage

// File: rtl/inagu_ctrl_if.sv
// Job/AGU/accumulator signal bundle for inagu_ctrl.
// master = job issuer + AGU + accumulator side, slave = the sequencer.
interface inagu_ctrl_if
    import inagu_ctrl_pkg::*;
#(
    parameter int BCNT   = DEF_BCNT,
    parameter int NJUMPS = DEF_NJUMPS
) ();
    logic              start;
    logic              start_rdy;
    logic [BCNT-1:0]   cfg_count;
    logic [NJUMPS-1:0] cfg_out_sel;
    logic              agu_clr;
    logic              agu_en;
    logic              agu_sh;
    logic [NJUMPS-1:0] agu_on_j;
    logic              shacc_load;
    logic              shacc_acc;
    logic              shacc_sh;
    logic              out_step;
    logic              busy;
    logic              done;

    modport master (
        output start, cfg_count, cfg_out_sel, agu_sh, agu_on_j,
        input  start_rdy, agu_clr, agu_en, shacc_load, shacc_acc, shacc_sh,
               out_step, busy, done
    );

    modport slave (
        input  start, cfg_count, cfg_out_sel, agu_sh, agu_on_j,
        output start_rdy, agu_clr, agu_en, shacc_load, shacc_acc, shacc_sh,
               out_step, busy, done
    );
endinterface

// File: rtl/inagu_ctrl_delay.sv
// ctrl_delay: DEPTH-stage shift register, synchronously cleared by clr.
// Aligns per-step control terms with operands arriving at the accumulator.
module ctrl_delay #(
    parameter int W     = 4,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [W-1:0] q_reg;
        if (gi == 0) begin : g_head
            // Head stage captures the raw term
            always_ff @(posedge clk) begin
                if (clr) q_reg <= '0;
                else     q_reg <= din;
            end
        end else begin : g_tail
            // Each later stage follows its predecessor by one cycle
            always_ff @(posedge clk) begin
                if (clr) q_reg <= '0;
                else     q_reg <= g_stage[gi-1].q_reg;
            end
        end
    end

    assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/inagu_ctrl.sv
// inagu_ctrl: job sequencer for the inagu address generators and shift-accumulator.
// IDLE -> CLEAR -> RUN (cfg_count steps) -> DRAIN (LATENCY cycles) -> DONE -> IDLE.
// Define INAGU_CTRL_STALL_EN to add a stall input that pauses stepping in RUN.
module inagu_ctrl
    import inagu_ctrl_pkg::*;
#(
    parameter int BCNT    = DEF_BCNT,
    parameter int NJUMPS  = DEF_NJUMPS,
    parameter int LATENCY = DEF_LATENCY
) (
    input logic clk,
    input logic clr,
`ifdef INAGU_CTRL_STALL_EN
    input logic stall,
`endif
    inagu_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] CLEAR = ST_CLEAR;
    localparam logic [2:0] RUN   = ST_RUN;
    localparam logic [2:0] DRAIN = ST_DRAIN;
    localparam logic [2:0] DONE  = ST_DONE;

    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [2:0]        state_reg, state_next;
    logic [BCNT-1:0]   count_reg;
    logic [NJUMPS-1:0] sel_reg;
    logic [DW-1:0]     drain_cnt_reg;
    logic              load_flag_reg;
    logic              step;
    logic              out_raw;
    term_t             raw_term;
    term_t             dly_term;
    logic [TERM_W-1:0] dly_bits;

`ifdef INAGU_CTRL_STALL_EN
    assign step = (state_reg == RUN) && !stall;
`else
    assign step = (state_reg == RUN);
`endif

    assign out_raw = |(sel_reg & bus.agu_on_j);

    // Raw term for this cycle; all-zero when no AGU step is issued
    always_comb begin
        raw_term = '0;
        if (step) begin
            raw_term.load = load_flag_reg;
            raw_term.acc  = 1'b1;
            raw_term.sh   = bus.agu_sh;
            raw_term.out  = out_raw;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = CLEAR;
            CLEAR:   state_next = (count_reg == '0) ? DRAIN : RUN;
            RUN:     if (step && count_reg == BCNT'(1)) state_next = DRAIN;
            DRAIN:   if (drain_cnt_reg == DW'(LATENCY - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, job config capture, step countdown, drain counter and load flag
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            sel_reg       <= '0;
            drain_cnt_reg <= '0;
            load_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.start) begin
                count_reg <= bus.cfg_count;
                sel_reg   <= bus.cfg_out_sel;
            end
            if (step) begin
                count_reg     <= count_reg - BCNT'(1);
                load_flag_reg <= out_raw;
            end
            // First term of a job always starts a fresh output
            if (state_reg == CLEAR) load_flag_reg <= 1'b1;
            if (state_reg == DRAIN) drain_cnt_reg <= drain_cnt_reg + DW'(1);
            else                    drain_cnt_reg <= '0;
        end
    end

    ctrl_delay #(
        .W     (TERM_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk  (clk),
        .clr  (clr),
        .din  (raw_term),
        .dout (dly_bits)
    );

    assign dly_term = qualify_term(term_t'(dly_bits));

    assign bus.start_rdy  = (state_reg == IDLE);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.agu_clr    = (state_reg == CLEAR);
    assign bus.agu_en     = step;
    assign bus.done       = (state_reg == DONE);
    assign bus.shacc_acc  = dly_term.acc;
    assign bus.shacc_load = dly_term.load;
    assign bus.shacc_sh   = dly_term.sh;
    assign bus.out_step   = dly_term.out;

endmodule

// File: tb/tb_inagu_ctrl.sv
// Directed bench for inagu_ctrl (LATENCY=3). Each job is captured over cycles
// 0..15 (cycle 0 = start presented, accepted at its closing edge) and every
// output trace is compared with a hand-derived 16-bit cycle mask.
module tb_inagu_ctrl;
    import inagu_ctrl_pkg::*;

    localparam int BCNT = 32;
    localparam int NJ   = 5;
    localparam int NCYC = 16;

    logic clk = 1'b0;
    logic clr;
`ifdef INAGU_CTRL_STALL_EN
    logic stall;
    logic stall_stim [NCYC];
`endif

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic          start_stim [NCYC];
    logic          clr_stim   [NCYC];
    logic          sh_stim    [NCYC];
    logic [NJ-1:0] onj_stim   [NCYC];
    int            cfg_cyc;
    logic [BCNT-1:0] cfg2_count;
    logic [NJ-1:0]   cfg2_sel;

    logic [15:0] cap_en, cap_clr, cap_acc, cap_load, cap_sh, cap_out;
    logic [15:0] cap_done, cap_busy, cap_rdy;

    inagu_ctrl_if #(.BCNT(BCNT), .NJUMPS(NJ)) bus ();

    inagu_ctrl #(.BCNT(BCNT), .NJUMPS(NJ), .LATENCY(3)) dut (
        .clk   (clk),
        .clr   (clr),
`ifdef INAGU_CTRL_STALL_EN
        .stall (stall),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < NCYC; k++) begin
            start_stim[k] = 1'b0;
            clr_stim[k]   = 1'b0;
            sh_stim[k]    = 1'b0;
            onj_stim[k]   = '0;
`ifdef INAGU_CTRL_STALL_EN
            stall_stim[k] = 1'b0;
`endif
        end
        cfg_cyc = -1;
    endtask

    // Called just after a rising edge; drives cycle k inputs, samples, advances.
    task automatic run_cycles();
        for (int k = 0; k < NCYC; k++) begin
            bus.start    = start_stim[k];
            clr          = clr_stim[k];
            bus.agu_sh   = sh_stim[k];
            bus.agu_on_j = onj_stim[k];
`ifdef INAGU_CTRL_STALL_EN
            stall        = stall_stim[k];
`endif
            if (k == cfg_cyc) begin
                bus.cfg_count   = cfg2_count;
                bus.cfg_out_sel = cfg2_sel;
            end
            #1;
            cap_en[k]   = bus.agu_en;
            cap_clr[k]  = bus.agu_clr;
            cap_acc[k]  = bus.shacc_acc;
            cap_load[k] = bus.shacc_load;
            cap_sh[k]   = bus.shacc_sh;
            cap_out[k]  = bus.out_step;
            cap_done[k] = bus.done;
            cap_busy[k] = bus.busy;
            cap_rdy[k]  = bus.start_rdy;
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b0;
        clr          = 1'b0;
        bus.agu_sh   = 1'b0;
        bus.agu_on_j = '0;
`ifdef INAGU_CTRL_STALL_EN
        stall        = 1'b0;
`endif
    endtask

    task automatic report(input string name);
        $display("job %s: en=%h clr=%h acc=%h load=%h sh=%h out=%h done=%h busy=%h rdy=%h",
                 name, cap_en, cap_clr, cap_acc, cap_load, cap_sh, cap_out,
                 cap_done, cap_busy, cap_rdy);
    endtask

    initial begin
        clr             = 1'b1;
        bus.start       = 1'b0;
        bus.cfg_count   = '0;
        bus.cfg_out_sel = '0;
        bus.agu_sh      = 1'b0;
        bus.agu_on_j    = '0;
`ifdef INAGU_CTRL_STALL_EN
        stall           = 1'b0;
`endif
        clear_stim();

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {23'd0, bus.start_rdy, bus.agu_clr, bus.agu_en, bus.shacc_load, bus.shacc_acc,
               bus.shacc_sh, bus.out_step, bus.busy, bus.done},
              32'h100);
        clr = 1'b0;
        run_cycles();
        report("idle");
        check("idle_agu_en", cap_en, 32'h0000);
        check("idle_busy", cap_busy, 32'h0000);

        // 2: four steps, output boundary on step 2
        clear_stim();
        bus.cfg_count   = 32'd4;
        bus.cfg_out_sel = 5'b00010;
        start_stim[0] = 1'b1;
        sh_stim[1] = 1'b1; sh_stim[3] = 1'b1; sh_stim[4] = 1'b1;
        onj_stim[1] = 5'b00010; onj_stim[2] = 5'b11101; onj_stim[3] = 5'b00010;
        onj_stim[4] = 5'b11101; onj_stim[5] = 5'b11101;
        run_cycles();
        report("count4");
        check("j2_agu_en", cap_en, 32'h003C);
        check("j2_agu_clr", cap_clr, 32'h0002);
        check("j2_acc", cap_acc, 32'h01E0);
        check("j2_load", cap_load, 32'h00A0);
        check("j2_out", cap_out, 32'h0040);
        check("j2_sh", cap_sh, 32'h00C0);
        check("j2_done", cap_done, 32'h0200);
        check("j2_busy", cap_busy, 32'h03FE);
        check("j2_rdy", cap_rdy, 32'hFC01);

        // 3: zero-length job
        clear_stim();
        bus.cfg_count   = 32'd0;
        bus.cfg_out_sel = 5'b11111;
        start_stim[0] = 1'b1;
        for (int k = 1; k < 6; k++) begin
            onj_stim[k] = 5'b11111;
            sh_stim[k]  = 1'b1;
        end
        run_cycles();
        report("count0");
        check("j3_agu_en", cap_en, 32'h0000);
        check("j3_acc", cap_acc, 32'h0000);
        check("j3_done", cap_done, 32'h0020);
        check("j3_busy", cap_busy, 32'h003E);
        check("j3_rdy", cap_rdy, 32'hFFC1);

        // 4: start held through a job, cfg changed mid-run, back-to-back accept
        clear_stim();
        bus.cfg_count   = 32'd2;
        bus.cfg_out_sel = 5'b00001;
        for (int k = 0; k < 9; k++) start_stim[k] = 1'b1;
        for (int k = 0; k < NCYC; k++) onj_stim[k] = 5'b00100;
        cfg_cyc    = 2;
        cfg2_count = 32'd1;
        cfg2_sel   = 5'b00100;
        run_cycles();
        report("held_start");
        check("j4_agu_en", cap_en, 32'h040C);
        check("j4_agu_clr", cap_clr, 32'h0202);
        check("j4_acc", cap_acc, 32'h2060);
        check("j4_load", cap_load, 32'h2020);
        check("j4_out", cap_out, 32'h2000);
        check("j4_done", cap_done, 32'h4080);
        check("j4_rdy", cap_rdy, 32'h8101);

        // 5: clr during RUN aborts the job
        clear_stim();
        bus.cfg_count   = 32'd10;
        bus.cfg_out_sel = 5'b00001;
        start_stim[0] = 1'b1;
        clr_stim[4]   = 1'b1;
        for (int k = 0; k < NCYC; k++) onj_stim[k] = 5'b00001;
        run_cycles();
        report("abort");
        check("j5_agu_en", cap_en, 32'h001C);
        check("j5_acc", cap_acc, 32'h0000);
        check("j5_done", cap_done, 32'h0000);
        check("j5_busy", cap_busy, 32'h001E);
        check("j5_rdy", cap_rdy, 32'hFFE1);

`ifdef INAGU_CTRL_STALL_EN
        // 6: one stall cycle in RUN; stalls in CLEAR and DRAIN have no effect
        clear_stim();
        bus.cfg_count   = 32'd3;
        bus.cfg_out_sel = 5'b00000;
        start_stim[0] = 1'b1;
        stall_stim[1] = 1'b1;
        stall_stim[3] = 1'b1;
        stall_stim[6] = 1'b1;
        run_cycles();
        report("stall");
        check("j6_agu_en", cap_en, 32'h0034);
        check("j6_acc", cap_acc, 32'h01A0);
        check("j6_load", cap_load, 32'h0020);
        check("j6_done", cap_done, 32'h0200);
        check("j6_busy", cap_busy, 32'h03FE);
        check("j6_rdy", cap_rdy, 32'hFC01);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
